decoder_scan_ctrl: RTL and testbench

- Sequencer that sits directly upstream of the 3-to-8 decoder and drives its select inputs (a, b, c) and enable (en).
- Cycles a 3-bit index through 0..7 (up or down) at a prescaled rate, with run, pause, single-step and idle control.
- Used to scan eight LEDs or digit lines through the decoder one at a time.

---
 rtl/decoder_scan_pkg.sv | 19 +
 rtl/decoder_scan_ctrl_tick.sv | 27 ++
 rtl/decoder_scan_ctrl.sv | 96 +++++++++
 tb/tb_decoder_scan_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/decoder_scan_pkg.sv
// Shared types and helpers for the decoder scan sequencer.
// Pure declarations: no logic, no latency.
package decoder_scan_pkg;

  localparam int IDX_W = 3;
  localparam logic [IDX_W-1:0] IDX_MAX = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  // Modulo-8 step in either direction; the index width makes wrap implicit.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx, input logic dn);
    return dn ? idx - 1'b1 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/decoder_scan_ctrl_tick.sv
// Prescaler: tick is combinational, high on the DIV-th consecutive run cycle.
// Count is held at zero whenever run is low; no backpressure.
module scan_tick_gen #(
  parameter int DIV   = 4,
  parameter int DIV_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick
);

  logic [DIV_W-1:0] count;

  assign tick = run && (count == DIV_W'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (!run || tick) begin
      count <= '0;
    end else begin
      count <= count + DIV_W'(1);
    end
  end

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Drives 3-to-8 decoder selects with a prescaled up/down index; run/pause/step/idle control.
// All outputs registered; first advance DIV cycles after start is sampled; no backpressure.
module decoder_scan_ctrl
  import decoder_scan_pkg::*;
#(
  parameter int DIV   = 4,
  parameter int DIV_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic stop,
  input  logic step,
  input  logic dir,
  output logic a,
  output logic b,
  output logic c,
  output logic en,
  output logic wrap
);

  state_t           state, state_nx;
  logic [IDX_W-1:0] idx, idx_nx;
  logic             en_q, en_nx;
  logic             wrap_q, wrap_nx;
  logic             tick;
  logic             adv;

  scan_tick_gen #(
    .DIV   (DIV),
    .DIV_W (DIV_W)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .run  (state == ST_RUN),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      idx    <= '0;
      en_q   <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      state  <= state_nx;
      idx    <= idx_nx;
      en_q   <= en_nx;
      wrap_q <= wrap_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    wrap_nx  = 1'b0;
    adv      = 1'b0;

    // stop outranks start in every state
    case (state)
      ST_IDLE: begin
        if (!stop && start) state_nx = ST_RUN;
      end
      ST_RUN: begin
        adv = tick;
        if (stop) state_nx = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (stop) begin
          state_nx = ST_IDLE;
          idx_nx   = '0;
        end else if (start) begin
          state_nx = ST_RUN;
        end else if (step) begin
          adv = 1'b1;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        idx_nx   = '0;
      end
    endcase

    if (adv) begin
      idx_nx  = next_idx(idx, dir);
      wrap_nx = dir ? (idx == '0) : (idx == IDX_MAX);
    end

    en_nx = (state_nx == ST_RUN) || (state_nx == ST_PAUSE);
  end

  assign {a, b, c} = idx;
  assign en        = en_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Bench: DIV=4 and DIV=1 instances share stimulus; a cycle model checks both every cycle.
module tb_decoder_scan_ctrl;

  logic clk = 1'b0;
  logic rst, start, stop, step, dir;
  logic a4, b4, c4, en4, wrap4;
  logic a1, b1, c1, en1, wrap1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decoder_scan_ctrl #(.DIV(4), .DIV_W(16)) u4 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .step(step), .dir(dir),
    .a(a4), .b(b4), .c(c4), .en(en4), .wrap(wrap4)
  );

  decoder_scan_ctrl #(.DIV(1), .DIV_W(16)) u1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .step(step), .dir(dir),
    .a(a1), .b(b1), .c(c1), .en(en1), .wrap(wrap1)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0=idle 1=run 2=pause; run_cyc counts cycles spent in run since last advance
  int m_mode[2];
  int m_idx[2];
  int m_cyc[2];
  int m_wrap[2];
  int divs[2] = '{4, 1};
  int nm, nidx, adv;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_mode[k] = 0; m_idx[k] = 0; m_cyc[k] = 0; m_wrap[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        nm = m_mode[k]; nidx = m_idx[k]; adv = 0;
        m_wrap[k] = 0;
        if (m_mode[k] == 0) begin
          if (start && !stop) nm = 1;
        end else if (m_mode[k] == 1) begin
          m_cyc[k] = m_cyc[k] + 1;
          if (m_cyc[k] == divs[k]) begin adv = 1; m_cyc[k] = 0; end
          if (stop) nm = 2;
        end else begin
          if (stop) begin nm = 0; nidx = 0; end
          else if (start) nm = 1;
          else if (step) adv = 1;
        end
        if (adv != 0) begin
          nidx = dir ? (m_idx[k] + 7) % 8 : (m_idx[k] + 1) % 8;
          m_wrap[k] = dir ? int'(m_idx[k] == 0) : int'(m_idx[k] == 7);
        end
        if (nm != 1) m_cyc[k] = 0;
        m_mode[k] = nm;
        m_idx[k] = nidx;
      end
    end
  end

  always @(negedge clk) begin
    chk("u4_idx", int'({a4, b4, c4}), m_idx[0]);
    chk("u4_en", int'(en4), int'(m_mode[0] != 0));
    chk("u4_wrap", int'(wrap4), m_wrap[0]);
    chk("u1_idx", int'({a1, b1, c1}), m_idx[1]);
    chk("u1_en", int'(en1), int'(m_mode[1] != 0));
    chk("u1_wrap", int'(wrap1), m_wrap[1]);
  end

  task automatic wait_idx4(input int v);
    int n = 0;
    while (int'({a4, b4, c4}) != v && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idx4", int'({a4, b4, c4}), v);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; step = 1'b0; dir = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_idx", int'({a4, b4, c4}), 0);
    chk("rst_en", int'(en4), 0);
    chk("rst_wrap", int'(wrap4), 0);
    chk("rst_en1", int'(en1), 0);

    // DIV=4 up-scan from a one-cycle start pulse
    rst = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("a_en", int'(en4), 1);
    chk("a_idx0", int'({a4, b4, c4}), 0);
    for (int i = 1; i <= 8; i++) begin
      repeat (4) @(negedge clk);
      chk("a_idx", int'({a4, b4, c4}), i % 8);
      chk("a_wrap", int'(wrap4), int'(i == 8));
    end
    @(negedge clk);
    chk("a_wrap_end", int'(wrap4), 0);
    chk("a_idx_hold", int'({a4, b4, c4}), 0);

    // asynchronous reset while running at index 5
    wait_idx4(5);
    #2 rst = 1'b1;
    #1;
    chk("ar_idx", int'({a4, b4, c4}), 0);
    chk("ar_en", int'(en4), 0);
    chk("ar_wrap", int'(wrap4), 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("ar_idle", int'(en4), 0);

    // pause at 3, hold, step three times, stop to idle
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_idx4(3);
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("p_hold", int'({a4, b4, c4}), 3);
      chk("p_en", int'(en4), 1);
    end
    step = 1'b1;
    for (int i = 4; i <= 6; i++) begin
      @(negedge clk);
      chk("p_step", int'({a4, b4, c4}), i);
    end
    step = 1'b0;
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    chk("p_idle_en", int'(en4), 0);
    chk("p_idle_idx", int'({a4, b4, c4}), 0);
    chk("p_idle_wrap", int'(wrap4), 0);

    // step wrap 7->0 in pause, then start+stop together
    start = 1'b1;
    @(negedge clk); start = 1'b0; stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    chk("w_pause_en", int'(en4), 1);
    step = 1'b1;
    repeat (7) @(negedge clk);
    chk("w_idx7", int'({a4, b4, c4}), 7);
    @(negedge clk); step = 1'b0;
    chk("w_idx0", int'({a4, b4, c4}), 0);
    chk("w_wrap", int'(wrap4), 1);
    start = 1'b1; stop = 1'b1;
    @(negedge clk); start = 1'b0; stop = 1'b0;
    chk("w_both_en", int'(en4), 0);

    // step ignored in idle; in run only prescaler ticks advance
    step = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("s_idle_en", int'(en4), 0);
      chk("s_idle_idx", int'({a4, b4, c4}), 0);
    end
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("s_run_en", int'(en4), 1);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("s_run_hold", int'({a4, b4, c4}), 0);
    end
    @(negedge clk);
    chk("s_run_tick", int'({a4, b4, c4}), 1);
    step = 1'b0;
    stop = 1'b1;
    repeat (2) @(negedge clk);
    stop = 1'b0;
    chk("s_stop_en", int'(en4), 0);

    // DIV=1 down-scan with start held, then a mid-scan direction change
    dir = 1'b1; start = 1'b1;
    @(negedge clk);
    chk("d_idx0", int'({a1, b1, c1}), 0);
    chk("d_en", int'(en1), 1);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      chk("d_idx", int'({a1, b1, c1}), (8 - i % 8) % 8);
      chk("d_wrap", int'(wrap1), int'(i % 8 == 1));
    end
    dir = 1'b0;
    repeat (5) @(negedge clk);
    dir = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0; stop = 1'b1;
    repeat (2) @(negedge clk);
    stop = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
